// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receive-side FIFO and its storage.
package uart_pkg;

    localparam int UART_DATA_W                = 8;
    localparam int UART_RX_FIFO_DEPTH_DEFAULT = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Status flags gathered in one place so checkers can bind to a single signal.
    typedef struct packed {
        logic full;
        logic empty;
        logic overrun;
        logic irq;
    } rx_fifo_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 storage: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  uart_byte_t    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output uart_byte_t    o_rdata
);

    uart_byte_t mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Show-ahead read: the head entry is visible combinationally.
    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and a byte consumer, with sticky overrun
// flag and a level interrupt on fill threshold or overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH_DEFAULT,
    parameter int THRESH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [UART_DATA_W-1:0]   i_data,
    input  logic                     i_data_valid,
    output logic [UART_DATA_W-1:0]   o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overrun,
    input  logic                     i_clr_overrun,
    output logic                     o_irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overrun_q, overrun_d;
    logic            push, pop, overrun_evt;
    logic            full, empty;
    rx_fifo_status_t status;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Handshake: the head byte transfers on any cycle with o_valid && i_ready.
    // The producer side has no back-pressure; i_data_valid is a strobe and a
    // byte offered while full is dropped unless a pop frees a slot that cycle.
    assign pop         = ~empty & i_ready;
    assign push        = i_data_valid & (~full | pop);
    assign overrun_evt = i_data_valid & full & ~pop;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A fresh drop outranks a clear arriving in the same cycle.
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end else if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_data),
        .i_raddr (rd_ptr_q),
        .o_rdata (o_data)
    );

    assign status.full    = full;
    assign status.empty   = empty;
    assign status.overrun = overrun_q;
    assign status.irq     = (count_q >= CW'(THRESH)) | overrun_q;

    assign o_count   = count_q;
    assign o_full    = status.full;
    assign o_empty   = status.empty;
    assign o_valid   = ~status.empty;
    assign o_overrun = status.overrun;
    assign o_irq     = status.irq;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; power of two, 4..256.
REQ-002 SHALL have parameter THRESH, default 8, fill level at which o_irq asserts; range 1..DEPTH.
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port i_data_valid  input  1  one-cycle strobe; i_data is valid this cycle.
REQ-007 SHALL have port o_data  output  8  byte at FIFO head.
REQ-008 SHALL have port o_valid  output  1  head byte available (FIFO not empty).
REQ-009 SHALL have port i_ready  input  1  consumer accepts head byte this cycle.
REQ-010 SHALL have port o_count  output  $clog2(DEPTH)+1  current fill level.
REQ-011 SHALL have port o_full  output  1  count == DEPTH.
REQ-012 SHALL have port o_empty  output  1  count == 0.
REQ-013 SHALL have port o_overrun  output  1  sticky flag: a byte was dropped.
REQ-014 SHALL have port i_clr_overrun  input  1  one-cycle strobe clearing o_overrun.
REQ-015 SHALL have port o_irq  output  1  level interrupt: count >= THRESH, or o_overrun set.

Function
REQ-016 Push SHALL occur when i_data_valid=1 and (count<DEPTH, or a pop occurs in the same cycle).
REQ-017 Pop SHALL occur when o_valid=1 and i_ready=1; o_data SHALL be show-ahead (head visible before pop, no read latency).
REQ-018 A byte pushed in cycle N SHALL appear on o_data with o_valid=1 in cycle N+1 when the FIFO was empty; no bypass in cycle N.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged, at every fill level, including full.
REQ-020 On an empty FIFO with i_data_valid=1 and i_ready=1: no pop; count SHALL become 1.
REQ-021 i_data_valid=1 while full without a pop SHALL drop the byte, leave storage/count unchanged, and set o_overrun next cycle.
REQ-022 o_overrun SHALL clear on i_clr_overrun; a simultaneous new overrun event SHALL win (flag stays 1).
REQ-023 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; order SHALL be strict FIFO across the wrap.
REQ-024 o_count, o_full, o_empty, o_valid, o_irq SHALL be registered-state-derived, reflecting the count after the previous edge.
REQ-025 o_valid SHALL equal ~o_empty at all times.
REQ-026 o_data SHALL be don't-care while o_valid=0; the bench SHALL NOT check it then.
REQ-027 Count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-028 While i_rst_n=0: pointers=0, count=0, o_overrun=0, o_valid=0, o_full=0, o_empty=1, o_irq=0.
REQ-029 Reset SHALL take effect immediately regardless of clock; in-flight data SHALL be discarded.
REQ-030 Storage array contents SHALL NOT be reset.
REQ-031 A strobe coincident with reset deassertion edge SHALL be ignored.

Structure
REQ-032 Shared package uart_pkg SHALL hold UART_DATA_W=8 and UART_RX_FIFO_DEPTH_DEFAULT=16.
REQ-033 Storage SHALL be a sub-module uart_fifo_mem (1 write port, 1 asynchronous read port, DEPTH x 8, no reset).
REQ-034 Pointer/count/flag control SHALL live in uart_rx_fifo.

Verification
REQ-035 Reset, then push 0x55, 0xAA, 0x0F with i_ready=0 -> count=3, o_data=0x55; raise i_ready -> bytes pop in order, then o_empty=1.
REQ-036 Push 16 bytes 0x00..0x0F, then a 17th byte 0xFF -> o_full=1, o_overrun=1, count=16; drain -> 0x00..0x0F, no 0xFF.
REQ-037 Full FIFO, push 0x77 with i_ready=1 in the same cycle -> count stays 16, o_overrun=0, 0x77 emerges last.
REQ-038 Push 8 bytes with THRESH=8 -> o_irq rises after the 8th; pop 1 -> o_irq falls; overrun with i_clr_overrun in the same cycle -> o_overrun=1.
REQ-039 Run 40 push/pop pairs to wrap the pointers twice with random i_ready -> output sequence equals input sequence.
REQ-040 Assert i_rst_n=0 mid-stream at count=5 -> outputs take reset values immediately without a clock edge; a following push of 0x3C is read back as the only byte.
